// File: rtl/morse_decoder.sv
// Straight-key Morse receiver: times marks/spaces, decodes A-Z letters.
// Optional MORSE_GLITCH_FILTER_EN adds a key stability filter.
module morse_decoder #(
  parameter int UNIT_CYCLES   = 16,
  parameter int CNT_W         = 12,
  parameter int GLITCH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       char_valid,
  output logic [4:0] char_code,
  output logic       char_err,
  output logic       word_gap,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LG_M1    = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WG_M1    = CNT_W'(5 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t           state, state_n;
  logic             key_m, key_s, key_f;
  logic [CNT_W-1:0] mark_cnt, space_cnt;
  logic [4:0]       pattern;
  logic [2:0]       sym_cnt;
  logic             ovf;
  logic             fire_char, fire_word, dash;
  logic [5:0]       dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
    end
  end

`ifdef MORSE_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic [GW-1:0] glt_cnt;

  // level moves only after key_s disagrees for GLITCH_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glt_cnt <= '0;
      key_f   <= 1'b0;
    end else if (key_s == key_f) begin
      glt_cnt <= '0;
    end else if (glt_cnt == GW'(GLITCH_CYCLES - 1)) begin
      glt_cnt <= '0;
      key_f   <= key_s;
    end else begin
      glt_cnt <= glt_cnt + 1'b1;
    end
  end
`else
  assign key_f = key_s;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  // returns {err, code}; pattern is LSB-first, 1 = dash
  function automatic logic [5:0] decode(input logic [2:0] n,
                                        input logic [3:0] p,
                                        input logic       o);
    logic [5:0] r;
    r = {1'b1, 5'd0};
    case ({n, p})
      {3'd2, 4'd2}:  r = 6'd0;
      {3'd4, 4'd1}:  r = 6'd1;
      {3'd4, 4'd5}:  r = 6'd2;
      {3'd3, 4'd1}:  r = 6'd3;
      {3'd1, 4'd0}:  r = 6'd4;
      {3'd4, 4'd4}:  r = 6'd5;
      {3'd3, 4'd3}:  r = 6'd6;
      {3'd4, 4'd0}:  r = 6'd7;
      {3'd2, 4'd0}:  r = 6'd8;
      {3'd4, 4'd14}: r = 6'd9;
      {3'd3, 4'd5}:  r = 6'd10;
      {3'd4, 4'd2}:  r = 6'd11;
      {3'd2, 4'd3}:  r = 6'd12;
      {3'd2, 4'd1}:  r = 6'd13;
      {3'd3, 4'd7}:  r = 6'd14;
      {3'd4, 4'd6}:  r = 6'd15;
      {3'd4, 4'd11}: r = 6'd16;
      {3'd3, 4'd2}:  r = 6'd17;
      {3'd3, 4'd0}:  r = 6'd18;
      {3'd1, 4'd1}:  r = 6'd19;
      {3'd3, 4'd4}:  r = 6'd20;
      {3'd4, 4'd8}:  r = 6'd21;
      {3'd3, 4'd6}:  r = 6'd22;
      {3'd4, 4'd9}:  r = 6'd23;
      {3'd4, 4'd13}: r = 6'd24;
      {3'd4, 4'd3}:  r = 6'd25;
      default:       r = {1'b1, 5'd0};
    endcase
    if (o) r = {1'b1, 5'd0};
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // threshold events take priority over a simultaneous key edge
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (key_f) state_n = MARK;
      MARK:  if (!key_f) state_n = SPACE;
      SPACE: begin
        if (space_cnt == LG_M1) state_n = GAP;
        else if (key_f)         state_n = MARK;
      end
      GAP: begin
        if (space_cnt == WG_M1) state_n = IDLE;
        else if (key_f)         state_n = MARK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fire_char = 1'b0;
    fire_word = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      MARK:  busy = 1'b1;
      SPACE: begin
        busy      = 1'b1;
        fire_char = (space_cnt == LG_M1);
      end
      GAP: begin
        busy      = 1'b1;
        fire_word = (space_cnt == WG_M1);
      end
      default: busy = 1'b0;
    endcase
  end

  assign dash = (mark_cnt >= DASH_MIN);
  assign dec  = decode(sym_cnt, pattern[3:0], ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark_cnt   <= '0;
      space_cnt  <= '0;
      pattern    <= '0;
      sym_cnt    <= '0;
      ovf        <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= '0;
      char_err   <= 1'b0;
      word_gap   <= 1'b0;
    end else begin
      char_valid <= fire_char;
      word_gap   <= fire_word;
      if (fire_char) begin
        char_err  <= dec[5];
        char_code <= dec[4:0];
      end
      unique case (state)
        IDLE: begin
          if (key_f) begin
            mark_cnt <= CNT_W'(1);
            pattern  <= '0;
            sym_cnt  <= '0;
            ovf      <= 1'b0;
          end
        end
        MARK: begin
          if (key_f) begin
            mark_cnt <= sat_inc(mark_cnt);
          end else begin
            if (sym_cnt < 3'd5) begin
              pattern <= pattern | (5'(dash) << sym_cnt);
              sym_cnt <= sym_cnt + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            space_cnt <= CNT_W'(1);
          end
        end
        SPACE: begin
          if (!fire_char && key_f) mark_cnt <= CNT_W'(1);
          else                     space_cnt <= sat_inc(space_cnt);
        end
        GAP: begin
          if (!fire_word && key_f) begin
            mark_cnt <= CNT_W'(1);
            pattern  <= '0;
            sym_cnt  <= '0;
            ovf      <= 1'b0;
          end else begin
            space_cnt <= sat_inc(space_cnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: letter table, latency, reset, glitch, saturation.
module tb_morse_decoder;

`ifdef MORSE_GLITCH_FILTER_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_err;
  logic       word_gap;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cv_seen = 0;

  typedef struct {
    logic [7:0] syms;
    int         len;
    logic [4:0] code;
    logic       err;
  } vec_t;

  typedef struct {
    bit         word;
    logic [4:0] code;
    logic       err;
  } ev_t;

  ev_t  sb[$];
  vec_t tbl[13];

  morse_decoder #(
    .UNIT_CYCLES(4),
    .CNT_W(12),
    .GLITCH_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .char_valid(char_valid),
    .char_code(char_code),
    .char_err(char_err),
    .word_gap(word_gap),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void push_char(logic [4:0] c, logic e);
    ev_t ev;
    ev.word = 1'b0;
    ev.code = c;
    ev.err  = e;
    sb.push_back(ev);
  endfunction

  function automatic void push_word();
    ev_t ev;
    ev.word = 1'b1;
    ev.code = '0;
    ev.err  = 1'b0;
    sb.push_back(ev);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid && word_gap) begin
        total++;
        bad++;
        $display("FAIL overlap char_valid=1 word_gap=1 required not both");
      end
      if (char_valid) begin
        ev_t e;
        cv_seen++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_char code=%0d err=%0d", char_code, char_err);
        end else begin
          e = sb.pop_front();
          if (e.word || char_code !== e.code || char_err !== e.err) begin
            bad++;
            $display("FAIL char got code=%0d err=%0d exp word=%0d code=%0d err=%0d",
                     char_code, char_err, e.word, e.code, e.err);
          end
        end
      end else if (word_gap) begin
        ev_t e;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word_gap");
        end else begin
          e = sb.pop_front();
          if (!e.word) begin
            bad++;
            $display("FAIL word_gap got word_gap exp char code=%0d err=%0d",
                     e.code, e.err);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [7:0] syms, input int len);
    for (int i = 0; i < len; i++) begin
      key_in = 1'b1;
      tick(syms[i] ? 12 : 4);
      key_in = 1'b0;
      if (i < len - 1) tick(4);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d required 0", name, sb.size());
      sb.delete();
    end
    tick(3);
  endtask

  initial begin
    int n;
    int cv0;
    bit busy_seen;

    tbl[0]  = '{8'h02, 2, 5'd0,  1'b0};
    tbl[1]  = '{8'h00, 1, 5'd4,  1'b0};
    tbl[2]  = '{8'h01, 1, 5'd19, 1'b0};
    tbl[3]  = '{8'h00, 3, 5'd18, 1'b0};
    tbl[4]  = '{8'h07, 3, 5'd14, 1'b0};
    tbl[5]  = '{8'h0B, 4, 5'd16, 1'b0};
    tbl[6]  = '{8'h0D, 4, 5'd24, 1'b0};
    tbl[7]  = '{8'h03, 4, 5'd25, 1'b0};
    tbl[8]  = '{8'h0E, 4, 5'd9,  1'b0};
    tbl[9]  = '{8'h0C, 4, 5'd0,  1'b1};
    tbl[10] = '{8'h1F, 5, 5'd0,  1'b1};
    tbl[11] = '{8'h00, 5, 5'd0,  1'b1};
    tbl[12] = '{8'h00, 6, 5'd0,  1'b1};

    rst_n  = 1'b0;
    key_in = 1'b0;
    tick(4);
    total++;
    if ({char_valid, char_code, char_err, word_gap, busy} !== 9'd0) begin
      bad++;
      $display("FAIL reset_state got=%b required=0",
               {char_valid, char_code, char_err, word_gap, busy});
    end
    rst_n = 1'b1;
    tick(3);

    // "A" with latency measured from the final key release
    push_char(5'd0, 1'b0);
    push_word();
    play(8'h02, 2);
    for (n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (char_valid) break;
    end
    total++;
    if (n != 10 + EXTRA) begin
      bad++;
      $display("FAIL char_latency got=%0d required=%0d", n, 10 + EXTRA);
    end
    for (n = n + 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (word_gap) break;
    end
    total++;
    if (n != 22 + EXTRA) begin
      bad++;
      $display("FAIL word_latency got=%0d required=%0d", n, 22 + EXTRA);
    end
    drain("A");

    for (int i = 0; i < 13; i++) begin
      push_char(tbl[i].code, tbl[i].err);
      push_word();
      play(tbl[i].syms, tbl[i].len);
      drain($sformatf("vec%0d", i));
    end

    // E, 12-cycle gap, T: two letters and a single word gap
    push_char(5'd4, 1'b0);
    push_char(5'd19, 1'b0);
    push_word();
    play(8'h00, 1);
    tick(12);
    play(8'h01, 1);
    drain("E_T");

    // saturating mark still classified as dash
    push_char(5'd19, 1'b0);
    push_word();
    key_in = 1'b1;
    tick(5000);
    key_in = 1'b0;
    drain("long_T");

    // reset mid-letter after two dots
    play(8'h00, 2);
    tick(2);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({char_valid, char_code, char_err, word_gap, busy} !== 9'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b required=0",
               {char_valid, char_code, char_err, word_gap, busy});
    end
    tick(2);
    rst_n = 1'b1;
    cv0 = cv_seen;
    tick(40);
    total++;
    if (cv_seen != cv0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset chars=%0d busy=%0d required 0 0",
               cv_seen - cv0, busy);
    end

    // 2-cycle key pulse while idle
    cv0 = cv_seen;
    busy_seen = 1'b0;
`ifndef MORSE_GLITCH_FILTER_EN
    push_char(5'd4, 1'b0);
    push_word();
`endif
    key_in = 1'b1;
    tick(2);
    key_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
`ifdef MORSE_GLITCH_FILTER_EN
    total++;
    if (busy_seen || cv_seen != cv0) begin
      bad++;
      $display("FAIL glitch busy=%0d chars=%0d required 0 0",
               busy_seen, cv_seen - cv0);
    end
`else
    total++;
    if (!busy_seen || cv_seen != cv0 + 1) begin
      bad++;
      $display("FAIL short_pulse busy=%0d chars=%0d required 1 1",
               busy_seen, cv_seen - cv0);
    end
`endif
    drain("pulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
